axi4lite_wr_master: RTL and testbench
=====================================

// Module: axi4lite_wr_master
// PURPOSE
//  AXI4-Lite write-only master: accepts one write command (addr/data/strb) on a valid/ready
//  command port and drives the AW, W and B channels toward a downstream AXI4-Lite slave.
//  Returns the slave's BRESP, or a timeout flag, with a one-cycle done pulse.
//  Sits between the local command source (CPU/test sequencer) and the write slave.
// PARAMETERS
//  ADDR_WIDTH      32   AWADDR / cmd_addr width
//  DATA_WIDTH      32   WDATA / cmd_data width (32 or 64)
//  STRB_WIDTH      DATA_WIDTH/8  WSTRB / cmd_strb width
//  TIMEOUT_CYCLES  256  max cycles per phase (ADDR_DATA, RESP) before abort; 0 disables
// PORTS
//  clk        in   1           clock, all logic on posedge
//  rst        in   1           asynchronous active-low reset
//  cmd_valid  in   1           command request
//  cmd_ready  out  1           high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_addr   in   ADDR_WIDTH  write address
//  cmd_data   in   DATA_WIDTH  write data
//  cmd_strb   in   STRB_WIDTH  byte strobes
//  done       out  1           one-cycle pulse at end of transaction
//  resp       out  2           BRESP of last transaction (held until next done)
//  timeout    out  1           set with done if aborted by timeout (held until next done)
//  AWADDR/AWVALID/AWREADY   out/out/in  ADDR_WIDTH/1/1  write address channel
//  WDATA/WSTRB/WVALID/WREADY out/out/out/in DATA_WIDTH/STRB_WIDTH/1/1  write data channel
//  BVALID/BRESP/BREADY      in/in/out  1/2/1  write response channel
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE; AWVALID=WVALID=BREADY=0; AWADDR=WDATA=WSTRB=0;
//   done=0; resp=2'b00; timeout=0; cmd_ready=1 after release. Mid-transaction reset drops all
//   VALIDs immediately; nothing is replayed.
//  All AXI outputs, done, resp, timeout are registered; cmd_ready = (state==IDLE).
//  FSM states: IDLE, ADDR_DATA, RESP, DONE.
//   IDLE: on cmd_valid -> latch addr/data/strb into AWADDR/WDATA/WSTRB, set AWVALID=WVALID=1,
//    clear aw_done/w_done, -> ADDR_DATA. AW/W valid first seen the cycle after acceptance.
//   ADDR_DATA: AWVALID drops the cycle after AWVALID&AWREADY at a posedge (aw_done=1);
//    WVALID likewise (w_done=1). Channels are independent; either may finish first or both
//    in the same cycle. When both done (counting handshakes this edge) -> RESP, BREADY=1.
//   RESP: on BVALID&BREADY -> BREADY=0, resp<=BRESP, timeout<=0, -> DONE.
//   DONE: done=1 for exactly one cycle, -> IDLE (new command accepted the following cycle).
//  VALID never depends on READY; once asserted, VALID and payload are held stable until handshake.
//  AWADDR/WDATA/WSTRB keep last value after handshake (not cleared).
//  Timeout: phase counter cleared on entry to ADDR_DATA and RESP, increments each cycle in
//   phase; reaching TIMEOUT_CYCLES-1 without completing -> AWVALID=WVALID=BREADY=0,
//   timeout<=1, resp<=2'b10, -> DONE. Completion in the same cycle as expiry wins (no timeout).
//   Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps. TIMEOUT_CYCLES=0: never fires.
//  Zero-wait slave latency: accept@0, AW/W hs @1, BREADY @2, B hs @2 or later, done = B hs + 1.
//  BVALID outside RESP is ignored (BREADY=0).
// STRUCTURE
//  Package axi4lite_pkg: resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11},
//   wr_mst_state_t enum (IDLE, ADDR_DATA, RESP, DONE), shared with the write slave/bench.
//  One sub-module: axi_phase_timer (clear, enable, expired) parameterised by TIMEOUT_CYCLES.
// TESTING
//  1 Zero-wait slave: cmd addr=32'h0000_1000 data=32'hDEAD_BEEF strb=4'hF -> AW/W hs same
//    cycle, BRESP=00, done pulse once, resp=00, timeout=0, cmd_ready back high.
//  2 AWREADY 3 cycles late, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held with
//    AWADDR stable until hs; BREADY only after both; done once.
//  3 WREADY first, then AWREADY; slave returns BRESP=2'b10 -> resp=2'b10, timeout=0.
//  4 TIMEOUT_CYCLES=8, slave never asserts AWREADY -> VALIDs drop after 8 cycles, done with
//    timeout=1, resp=2'b10; next command completes normally.
//  5 Back-to-back: cmd_valid held high with 2 commands -> second accepted cycle after done;
//    spurious BVALID in IDLE ignored.
//  6 rst low while in RESP -> BREADY/AWVALID/WVALID 0 asynchronously, no done; recovers to IDLE.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types for the write master, the write slave and their benches.
package axi4lite_pkg;

  // Write response codes carried on BRESP.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Write master sequencing: command accept, address/data phase, response wait, done pulse.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ADDR_DATA = 2'b01,
    RESP      = 2'b10,
    DONE      = 2'b11
  } wr_mst_state_t;

  // Width of a phase counter able to hold 0..cycles; never narrower than one bit so a
  // disabled timer (cycles == 0) still has a legal vector.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axi_phase_timer.sv
// Per-phase watchdog: counts cycles while enabled, restarts on clear, and flags the cycle
// in which the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES == 0 disables the flag.
module axi_phase_timer
  import axi4lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT_CYCLES);
  localparam bit TIMER_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count up while enabled and hold at all-ones.
  always_comb begin
    // NOTE: assigning every always_comb output a default first keeps each path covered,
    // so no branch can leave a value unassigned and infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is written with non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = TIMER_ON && enable && (count_q == LAST);

endmodule

// File: rtl/axi4lite_wr_master.sv
// AXI4-Lite write-only master. Takes one command at a time, drives AW and W independently,
// waits for B, and reports BRESP (or a timeout abort) with a single-cycle done pulse.
module axi4lite_wr_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // local command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  done,
  output logic [1:0]            resp,
  output logic                  timeout,
  // write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  // write response channel
  input  logic                  BVALID,
  input  logic [1:0]            BRESP,
  output logic                  BREADY
);

  wr_mst_state_t         state_q,   state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  done_q,    done_d;
  resp_t                 resp_q,    resp_d;
  logic                  timeout_q, timeout_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  logic aw_hs, w_hs, b_hs;
  logic aw_fin, w_fin;

  // Handshakes happening at the coming edge; a channel is finished once it has
  // handshaken now or in an earlier cycle of this transaction.
  assign aw_hs  = awvalid_q & AWREADY;
  assign w_hs   = wvalid_q & WREADY;
  assign b_hs   = bready_q & BVALID;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  // The watchdog runs in both waiting phases and restarts on entry to each.
  assign timer_enable = (state_q == ADDR_DATA) || (state_q == RESP);

  axi_phase_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Next-state and next-output logic; payload registers keep their last value.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    done_d      = 1'b0;
    resp_d      = resp_q;
    timeout_d   = timeout_q;
    timer_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          awaddr_d    = cmd_addr;
          wdata_d     = cmd_data;
          wstrb_d     = cmd_strb;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          timer_clear = 1'b1;
          state_d     = ADDR_DATA;
        end
      end

      ADDR_DATA: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Completion is tested before expiry so a last-cycle handshake is not aborted.
        if (aw_fin && w_fin) begin
          bready_d    = 1'b1;
          timer_clear = 1'b1;
          state_d     = RESP;
        end else if (timer_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          timeout_d = 1'b1;
          resp_d    = SLVERR;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      RESP: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          resp_d    = resp_t'(BRESP);
          timeout_d = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (timer_expired) begin
          bready_d  = 1'b0;
          timeout_d = 1'b1;
          resp_d    = SLVERR;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs; reset drops every VALID/READY at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= OKAY;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign resp      = resp_q;
  assign timeout   = timeout_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;

endmodule

// File: tb/tb_axi4lite_wr_master.sv
// Self-checking bench for axi4lite_wr_master: a cycle-counting slave with per-transaction
// ready/response delays, and a reference model that predicts outcome and timing from the
// delays alone.
module tb_axi4lite_wr_master;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        done;
  logic [1:0]  resp;
  logic        timeout;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;

  axi4lite_wr_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .STRB_WIDTH    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_strb (cmd_strb),
    .done     (done),
    .resp     (resp),
    .timeout  (timeout),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BVALID   (BVALID),
    .BRESP    (BRESP),
    .BREADY   (BREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] last_resp = 2'b00;
  logic       last_to   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model. Edges are counted from the accept edge (edge 0). A channel whose slave
  // waits d cycles handshakes at edge d+1; the address/data phase must complete by edge TO,
  // the response phase within TO edges of its start; done is visible after the final edge.
  function automatic void model(input int ad, input int wd, input int bd, input logic [1:0] br,
                                output int done_edge, output logic [1:0] r, output logic to,
                                output int aw_cyc, output int w_cyc, output int b_cyc);
    int mx;
    int m;
    mx     = (ad > wd) ? ad : wd;
    aw_cyc = (ad + 1 < TO) ? ad + 1 : TO;
    w_cyc  = (wd + 1 < TO) ? wd + 1 : TO;
    if (mx >= TO) begin
      done_edge = TO;
      r         = 2'b10;
      to        = 1'b1;
      b_cyc     = 0;
    end else begin
      m = mx + 1;
      if (bd >= TO) begin
        done_edge = m + TO;
        r         = 2'b10;
        to        = 1'b1;
        b_cyc     = TO;
      end else begin
        done_edge = m + bd + 1;
        r         = br;
        to        = 1'b0;
        b_cyc     = bd + 1;
      end
    end
  endfunction

  // One transaction: starts and ends on a negedge with the DUT idle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int ad, input int wd, input int bd, input logic [1:0] br,
                         input bit keep_valid);
    int exp_done, exp_aw, exp_w, exp_b;
    logic [1:0] exp_r;
    logic exp_to;
    int k, aw_edge, w_edge, both_edge, b_edge, done_edge, done_cnt, aw_cyc, w_cyc, b_cyc;
    logic [1:0] got_r;
    logic got_to;
    bit bad_payload, bad_order;

    model(ad, wd, bd, br, exp_done, exp_r, exp_to, exp_aw, exp_w, exp_b);

    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_strb  = strb;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    check("resp_hold", resp, last_resp);
    check("timeout_hold", timeout, last_to);
    @(posedge clk);

    k = 0; aw_edge = -1; w_edge = -1; both_edge = -1; b_edge = -1; done_edge = -1;
    done_cnt = 0; aw_cyc = 0; w_cyc = 0; b_cyc = 0; bad_payload = 0; bad_order = 0;
    got_r = 2'b00; got_to = 1'b0;

    while (k < 60) begin
      @(negedge clk);
      if (!keep_valid) cmd_valid = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          got_r     = resp;
          got_to    = timeout;
        end
      end
      if (done_edge >= 0 && k > done_edge) break;

      if (AWVALID) begin
        aw_cyc++;
        if (AWADDR !== addr) bad_payload = 1;
      end
      if (WVALID) begin
        w_cyc++;
        if (WDATA !== data || WSTRB !== strb) bad_payload = 1;
      end
      if (BREADY) begin
        b_cyc++;
        if (AWVALID || WVALID || both_edge < 0 || k < both_edge) bad_order = 1;
      end

      AWREADY = (k >= ad);
      WREADY  = (k >= wd);
      if (AWVALID && AWREADY && aw_edge < 0) aw_edge = k + 1;
      if (WVALID && WREADY && w_edge < 0) w_edge = k + 1;
      if (aw_edge >= 0 && w_edge >= 0 && both_edge < 0)
        both_edge = (aw_edge > w_edge) ? aw_edge : w_edge;
      BVALID = (both_edge >= 0) && (b_edge < 0) && (k >= both_edge + bd);
      BRESP  = br;
      if (BVALID && BREADY && b_edge < 0) b_edge = k + 1;
      k++;
    end

    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;

    if (done_edge < 0) begin
      check("done_seen", 1'b0, 1'b1);
    end else begin
      check("done_edge", done_edge, exp_done);
      check("done_pulses", done_cnt, 1);
      check("resp", got_r, exp_r);
      check("timeout", got_to, exp_to);
      check("cmd_ready_after", cmd_ready, 1'b1);
      check("aw_valid_cycles", aw_cyc, exp_aw);
      check("w_valid_cycles", w_cyc, exp_w);
      check("bready_cycles", b_cyc, exp_b);
      check("payload_stable", bad_payload, 1'b0);
      check("bready_order", bad_order, 1'b0);
    end
    last_resp = exp_r;
    last_to   = exp_to;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit spur_bad;
    int k;

    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    check("rst_awaddr", AWADDR, 32'h0);
    check("rst_wdata", WDATA, 32'h0);
    check("rst_wstrb", WSTRB, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_resp", resp, 2'b00);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("cmd_ready_release", cmd_ready, 1'b1);

    // Directed scenarios.
    run_txn(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    run_txn(32'h0000_2004, 32'h1234_5678, 4'h3, 3, 0, 1, 2'b00, 1'b0);
    run_txn(32'h0000_3008, 32'hCAFE_F00D, 4'hC, 3, 1, 2, 2'b10, 1'b0);
    run_txn(32'h0000_400C, 32'h0BAD_CAFE, 4'hF, NEVER, 0, 0, 2'b00, 1'b0);
    run_txn(32'h0000_5010, 32'hA5A5_5A5A, 4'h1, 0, 0, 0, 2'b00, 1'b0);
    run_txn(32'h0000_6014, 32'h0F0F_F0F0, 4'hF, 1, 1, NEVER, 2'b01, 1'b0);
    run_txn(32'h0000_7018, 32'h1111_2222, 4'hF, 7, 2, 7, 2'b11, 1'b0);
    run_txn(32'h0000_801C, 32'h3333_4444, 4'hF, 2, 8, 0, 2'b00, 1'b0);

    // BVALID while idle must be ignored.
    spur_bad = 0;
    BVALID = 1'b1;
    BRESP  = 2'b11;
    repeat (3) begin
      @(negedge clk);
      if (BREADY || done || !cmd_ready) spur_bad = 1;
    end
    BVALID = 1'b0;
    check("spurious_bvalid", spur_bad, 1'b0);

    // Back-to-back: cmd_valid stays high across the first transaction.
    run_txn(32'h0000_9020, 32'h5555_6666, 4'hF, 0, 0, 0, 2'b01, 1'b1);
    run_txn(32'h0000_A024, 32'h7777_8888, 4'h6, 1, 0, 1, 2'b00, 1'b0);

    // Randomised transactions, including delays that hit or pass the timeout.
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              int'($urandom_range(0, 9)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while waiting for the response.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_B028;
    cmd_data  = 32'h9999_AAAA;
    cmd_strb  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    AWREADY   = 1'b1;
    WREADY    = 1'b1;
    k = 0;
    while (!BREADY && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_resp", BREADY, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_bready", BREADY, 1'b0);
    check("async_rst_awvalid", AWVALID, 1'b0);
    check("async_rst_wvalid", WVALID, 1'b0);
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    spur_bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) spur_bad = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) spur_bad = 1;
    check("rst_no_done", spur_bad, 1'b0);
    check("rst_recover_ready", cmd_ready, 1'b1);
    last_resp = 2'b00;
    last_to   = 1'b0;
    run_txn(32'h0000_C02C, 32'hBBBB_CCCC, 4'hF, 1, 2, 0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
